// File: rtl/p_pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: I-fetch tracking states and the
// bundle of register enable/flush controls driven into the datapath.
package p_pipeline_ctrl_pkg;

    localparam logic [1:0] I_IDLE_ENC    = 2'd0;
    localparam logic [1:0] I_WAIT_ENC    = 2'd1;
    localparam logic [1:0] I_DISCARD_ENC = 2'd2;

    typedef enum logic [1:0] {
        I_IDLE    = I_IDLE_ENC,
        I_WAIT    = I_WAIT_ENC,
        I_DISCARD = I_DISCARD_ENC
    } i_state_t;

    typedef struct packed {
        logic load_pc;
        logic pc_redirect;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
    } pipe_ctrl_t;

endpackage

// File: rtl/p_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module p_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/p_pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module p_pipeline_ctrl
    import p_pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             load_use,
    input  logic             br_mispredict,
    output logic             load_pc,
    output logic             pc_redirect,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] istall_cnt,
    output logic [CNT_W-1:0] dstall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    i_state_t   i_state, i_state_nxt;
    logic       redirect_pend, redirect_pend_nxt;
    logic       dstall, istall, redirect_fire;
    pipe_ctrl_t ctrl;

    assign dstall = dmem_req & ~dmem_resp;
    assign istall = (i_state != I_IDLE) ? ~imem_resp : (imem_req & ~imem_resp);

    // A deferred redirect is applied once the wrong-path fetch has returned; if that
    // return coincided with a D-side stall the redirect waits in I_IDLE instead of being lost.
    assign redirect_fire = redirect_pend &
                           ((i_state == I_DISCARD) ? imem_resp : (i_state == I_IDLE));

    always_comb begin
        i_state_nxt       = i_state;
        redirect_pend_nxt = redirect_pend;
        ctrl              = '0;
        if (!rst) begin
            unique case (i_state)
                I_IDLE:    if (imem_req && !imem_resp) i_state_nxt = I_WAIT;
                I_WAIT:    if (imem_resp && !redirect_pend) i_state_nxt = I_IDLE;
                I_DISCARD: if (imem_resp) i_state_nxt = I_IDLE;
                default:   i_state_nxt = I_IDLE;
            endcase

            if (dstall) begin
                ctrl = '0;
            end else if (br_mispredict) begin
                ctrl.load_if_id  = 1'b1;
                ctrl.load_id_ex  = 1'b1;
                ctrl.load_ex_mem = 1'b1;
                ctrl.load_mem_wb = 1'b1;
                ctrl.flush_if_id = 1'b1;
                ctrl.flush_id_ex = 1'b1;
                if (istall) begin
                    i_state_nxt       = I_DISCARD;
                    redirect_pend_nxt = 1'b1;
                end else begin
                    ctrl.load_pc      = 1'b1;
                    ctrl.pc_redirect  = 1'b1;
                    i_state_nxt       = I_IDLE;
                    redirect_pend_nxt = 1'b0;
                end
            end else if (redirect_fire) begin
                ctrl.load_pc      = 1'b1;
                ctrl.pc_redirect  = 1'b1;
                ctrl.load_if_id   = 1'b1;
                ctrl.load_id_ex   = 1'b1;
                ctrl.load_ex_mem  = 1'b1;
                ctrl.load_mem_wb  = 1'b1;
                ctrl.flush_if_id  = 1'b1;
                redirect_pend_nxt = 1'b0;
            end else if (load_use || istall) begin
                ctrl.flush_id_ex = 1'b1;
                ctrl.load_id_ex  = 1'b1;
                ctrl.load_ex_mem = 1'b1;
                ctrl.load_mem_wb = 1'b1;
            end else begin
                ctrl.load_pc     = 1'b1;
                ctrl.load_if_id  = 1'b1;
                ctrl.load_id_ex  = 1'b1;
                ctrl.load_ex_mem = 1'b1;
                ctrl.load_mem_wb = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_state       <= I_IDLE;
            redirect_pend <= 1'b0;
        end else begin
            i_state       <= i_state_nxt;
            redirect_pend <= redirect_pend_nxt;
        end
    end

    assign load_pc     = ctrl.load_pc;
    assign pc_redirect = ctrl.pc_redirect;
    assign load_if_id  = ctrl.load_if_id;
    assign load_id_ex  = ctrl.load_id_ex;
    assign load_ex_mem = ctrl.load_ex_mem;
    assign load_mem_wb = ctrl.load_mem_wb;
    assign flush_if_id = ctrl.flush_if_id;
    assign flush_id_ex = ctrl.flush_id_ex;

`ifdef PIPE_PERF_CNT_EN
    logic istall_inc, dstall_inc, flush_inc;

    assign istall_inc = istall & ~rst;
    assign dstall_inc = dstall & ~rst;
    assign flush_inc  = br_mispredict & ~dstall & ~rst;

    p_sat_counter #(.CNT_W(CNT_W)) u_istall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (istall_inc),
        .count (istall_cnt)
    );

    p_sat_counter #(.CNT_W(CNT_W)) u_dstall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (dstall_inc),
        .count (dstall_cnt)
    );

    p_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`else
    assign istall_cnt = '0;
    assign dstall_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_p_pipeline_ctrl.sv
// Directed bench for p_pipeline_ctrl; counter expectations follow PIPE_PERF_CNT_EN.
module tb_p_pipeline_ctrl;

    localparam int unsigned CNT_W = 32;

    // {load_pc, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
    localparam logic [7:0] RUN       = 8'b1_0_1111_00;
    localparam logic [7:0] FREEZE    = 8'b0_0_0000_00;
    localparam logic [7:0] BUBBLE    = 8'b0_0_0111_01;
    localparam logic [7:0] MISP      = 8'b1_1_1111_11;
    localparam logic [7:0] MISP_DEF  = 8'b0_0_1111_11;
    localparam logic [7:0] DISC_EXIT = 8'b1_1_1111_10;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_req, imem_resp, dmem_req, dmem_resp, load_use, br_mispredict;
    logic             load_pc, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic             flush_if_id, flush_id_ex;
    logic [CNT_W-1:0] istall_cnt, dstall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    p_pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_resp     (imem_resp),
        .dmem_req      (dmem_req),
        .dmem_resp     (dmem_resp),
        .load_use      (load_use),
        .br_mispredict (br_mispredict),
        .load_pc       (load_pc),
        .pc_redirect   (pc_redirect),
        .load_if_id    (load_if_id),
        .load_id_ex    (load_id_ex),
        .load_ex_mem   (load_ex_mem),
        .load_mem_wb   (load_mem_wb),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .istall_cnt    (istall_cnt),
        .dstall_cnt    (dstall_cnt),
        .flush_cnt     (flush_cnt)
    );

    // Inputs are {rst, imem_req, imem_resp, dmem_req, dmem_resp, load_use, br_mispredict};
    // applied just after a rising edge, outputs compared on the falling edge.
    task automatic step(input string tag, input logic [6:0] in, input logic [7:0] exp);
        logic [7:0] obs;
        {rst, imem_req, imem_resp, dmem_req, dmem_resp, load_use, br_mispredict} = in;
        @(negedge clk);
        obs = {load_pc, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int unsigned ei, input int unsigned ed,
                             input int unsigned ef);
        logic [CNT_W-1:0] xi, xd, xf;
`ifdef PIPE_PERF_CNT_EN
        xi = CNT_W'(ei);
        xd = CNT_W'(ed);
        xf = CNT_W'(ef);
`else
        xi = '0;
        xd = '0;
        xf = '0;
        if (ei + ed + ef == 0) xi = '0;
`endif
        checks++;
        assert ({istall_cnt, dstall_cnt, flush_cnt} === {xi, xd, xf}) else begin
            errors++;
            $error("FAIL %s: observed i=%0d d=%0d f=%0d expected i=%0d d=%0d f=%0d",
                   tag, istall_cnt, dstall_cnt, flush_cnt, xi, xd, xf);
        end
    endtask

    initial begin
        {rst, imem_req, imem_resp, dmem_req, dmem_resp, load_use, br_mispredict} = 7'b1_000000;
        @(posedge clk);
        #1;
        step("reset_hold", 7'b1_000000, FREEZE);
        check_cnt("reset_cnt", 0, 0, 0);

        for (int i = 0; i < 10; i++) step("no_stall", 7'b0_000000, RUN);

        step("dstall_c1", 7'b0_001000, FREEZE);
        step("dstall_c2", 7'b0_001000, FREEZE);
        step("dstall_c3", 7'b0_001000, FREEZE);
        step("dstall_resp", 7'b0_001100, RUN);
        check_cnt("dstall_cnt", 0, 3, 0);
        step("dmem_hit", 7'b0_001100, RUN);

        step("load_use", 7'b0_000010, BUBBLE);
        step("after_load_use", 7'b0_000000, RUN);

        step("imiss_c1", 7'b0_100000, BUBBLE);
        step("imiss_misp", 7'b0_100001, MISP_DEF);
        step("discard_c3", 7'b0_100000, BUBBLE);
        step("discard_c4", 7'b0_100000, BUBBLE);
        step("discard_exit", 7'b0_110000, DISC_EXIT);
        step("after_discard", 7'b0_000000, RUN);
        check_cnt("discard_cnt", 4, 3, 1);

        step("misp_dstall_c1", 7'b0_001001, FREEZE);
        step("misp_dstall_c2", 7'b0_001001, FREEZE);
        step("misp_dstall_rel", 7'b0_001101, MISP);
        step("after_misp_dstall", 7'b0_000000, RUN);
        check_cnt("misp_dstall_cnt", 4, 5, 2);

        step("iwait_enter", 7'b0_100000, BUBBLE);
        step("iwait_resp_misp", 7'b0_010001, MISP);
        step("iwait_idle_after", 7'b0_000000, RUN);
        check_cnt("resp_misp_cnt", 5, 5, 3);

        step("rst_fetch_start", 7'b0_100000, BUBBLE);
        step("rst_in_wait", 7'b1_100000, FREEZE);
        check_cnt("rst_mid_cnt", 0, 0, 0);
        step("stray_resp", 7'b0_010000, RUN);
        step("after_stray", 7'b0_000000, RUN);
        check_cnt("stray_cnt", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
